// File: rtl/dmem_if.sv
// Purpose : Mem-stage load/store bus between the pipeline (master) and the
//           data-memory responder (slave).
// Signals : req_valid/req_write/req_addr/req_wdata  master -> slave request
//           req_ready                              slave -> master accept
//           resp_valid/resp_rdata/resp_err         slave -> master response
//           stall                                  slave -> hazard unit
interface dmem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Purpose : Multi-cycle data-memory slave for the Mem-stage port. Accepts one
//           word request in IDLE, waits LATENCY edges, emits a one-cycle
//           response and drives a combinational stall for the hazard unit.
// Ports   : clk  rising-edge clock
//           rst  synchronous reset, active-high (clears FSM and the array)
//           bus  dmem_if.slave (request, response and stall signals)
// Params  : DEPTH   number of 32-bit words (power of two, >= 2)
//           LATENCY edges from acceptance to response (>= 1)
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      mem_q [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;

  logic [IDX_W-1:0] idx_q;
  logic             misal_q;

  assign idx_q   = addr_q[IDX_W+1:2];
  assign misal_q = (addr_q[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr[IDX_W+1:0];
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            // Single-edge latency: the acceptance edge is also the edge
            // entering RESP, so the store commits straight from the bus.
            state_d = S_RESP;
            wr_en   = bus.req_write && (bus.req_addr[1:0] == 2'b00);
            wr_idx  = bus.req_addr[IDX_W+1:2];
            wr_data = bus.req_wdata;
          end else begin
            // Acceptance edge counts as the first of LATENCY edges and the
            // WAIT->RESP edge as the last, so LATENCY-2 more remain.
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          wr_en   = write_q && !misal_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and array: both cleared by reset, so an aborted store
  // never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      if (wr_en) mem_q[wr_idx] <= wr_data;
    end
  end

  // Latched request payload: only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && misal_q;
  assign bus.resp_rdata = ((state_q == S_RESP) && !write_q && !misal_q) ? mem_q[idx_q] : 32'h0;
  // Low in RESP so the pipeline advances on the edge that consumes rdata.
  assign bus.stall      = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if if0 ();
  dmem_if if1 ();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic        rdy [2];
  logic        rv  [2];
  logic        err [2];
  logic        stl [2];
  logic [31:0] rd  [2];

  assign rdy[0] = if0.req_ready;  assign rdy[1] = if1.req_ready;
  assign rv[0]  = if0.resp_valid; assign rv[1]  = if1.resp_valid;
  assign err[0] = if0.resp_err;   assign err[1] = if1.resp_err;
  assign stl[0] = if0.stall;      assign stl[1] = if1.stall;
  assign rd[0]  = if0.resp_rdata; assign rd[1]  = if1.resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int lat [2] = '{2, 1};

  // Reference memory: one word array per responder, indexed by byte addr / 4
  // modulo 256.
  logic [31:0] mem_m [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int u, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (u == 0) begin
      if0.req_valid = v; if0.req_write = w; if0.req_addr = a; if0.req_wdata = d;
    end else begin
      if1.req_valid = v; if1.req_write = w; if1.req_addr = a; if1.req_wdata = d;
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++) mem_m[u][i] = 32'h0;
  endtask

  // One complete access on responder u with full timing and data checks.
  task automatic access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic        mis;
    logic [31:0] exp_rd;
    int          idx;
    @(negedge clk);
    set_req(u, 1'b1, w, a, d);
    #1;
    chk("acc_ready", 32'(rdy[u]), 32'd1);
    chk("acc_stall", 32'(stl[u]), 32'd1);
    @(posedge clk); #1;
    // Request fields change after acceptance; the responder must ignore them.
    set_req(u, 1'b0, 1'($urandom), $urandom, $urandom);
    n = 1;
    while (!rv[u] && n < 8) begin
      chk("wait_stall", 32'(stl[u]), 32'd1);
      chk("wait_ready", 32'(rdy[u]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    idx = int'(a[9:2]);
    mis = (a[1:0] != 2'b00);
    exp_rd = (mis || w) ? 32'h0 : mem_m[u][idx];
    if (!mis && w) mem_m[u][idx] = d;
    chk("resp_valid", 32'(rv[u]), 32'd1);
    chk("latency", 32'(n), 32'(lat[u]));
    chk("rdata", rd[u], exp_rd);
    chk("err", 32'(err[u]), 32'(mis));
    chk("resp_stall", 32'(stl[u]), 32'd0);
    chk("resp_ready", 32'(rdy[u]), 32'd0);
    @(posedge clk); #1;
    chk("post_valid", 32'(rv[u]), 32'd0);
    chk("post_ready", 32'(rdy[u]), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        chk("idle_ready", 32'(rdy[u]), 32'd1);
        chk("idle_stall", 32'(stl[u]), 32'd0);
        chk("idle_valid", 32'(rv[u]), 32'd0);
        if (k == 0) begin
          chk("idle_rdata", rd[u], 32'h0);
          chk("idle_err", 32'(err[u]), 32'd0);
        end
      end
    end

    // Store then load, misaligned load, address wrap
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0);
    chk("st_ld_value", mem_m[0][4], 32'hDEADBEEF);
    access(0, 1'b0, 32'h13, 32'h0);
    access(0, 1'b1, 32'h12, 32'hBAD0BAD0);
    access(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b1, 32'h400, 32'h5);
    access(0, 1'b0, 32'h0, 32'h0);

    // Reset during WAIT aborts the store
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h1234);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("abort_wait_stall", 32'(stl[0]), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(rv[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    chk("abort_stall", 32'(stl[0]), 32'd0);
    clear_model();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid2", 32'(rv[0]), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0);

    // LATENCY=1 back-to-back loads with valid held high
    access(1, 1'b1, 32'h44, 32'hCAFE0123);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("b2b_valid", 32'(rv[1]), 32'((k % 2) == 0));
      chk("b2b_ready", 32'(rdy[1]), 32'((k % 2) != 0));
      if ((k % 2) == 0) chk("b2b_rdata", rd[1], 32'hCAFE0123);
    end
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic on both responders
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 40; i++) begin
        w = 1'($urandom_range(0, 1));
        a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 10);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        access(u, w, a, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
